// File: rtl/input_packet_queue.sv
// input_packet_queue: assembles a serial word stream into fixed-length packets and
// queues up to DEPTH complete packets for the router core.
// Optional per-word even-parity checking is built when INBUF_PARITY_EN is defined.
module input_packet_queue #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PKT_BYTES = 4,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             node_transfering,
    input  logic [DATA_W-1:0]                data_in,
`ifdef INBUF_PARITY_EN
    input  logic                             data_parity_in,
`endif
    output logic                             in_ready,
    input  logic                             data_routed,
    output logic                             pkt_valid,
    output logic [PKT_BYTES-1:0][DATA_W-1:0] pkt_data,
`ifdef INBUF_PARITY_EN
    output logic                             pkt_error,
`endif
    output logic [$clog2(DEPTH+1)-1:0]       pkt_count,
    output logic                             overflow
);

    localparam int unsigned WcntW = $clog2(PKT_BYTES);
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    typedef logic [PKT_BYTES-1:0][DATA_W-1:0] pkt_t;

    logic [WcntW-1:0] wcnt_q, wcnt_d;
    pkt_t             asm_q, asm_d;
    pkt_t             mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             last_word, full, accept, push, pop;
    logic [WcntW-1:0] idx;
    pkt_t             pkt_next;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Handshake, write index and the packet as it will look after this word lands
    always_comb begin
        last_word = (wcnt_q == WcntW'(PKT_BYTES - 1));
        full      = (cnt_q == CntW'(DEPTH));
        // Only the final word of a packet needs a free slot
        in_ready  = !last_word || !full;
        accept    = node_transfering && in_ready;
        push      = accept && last_word;
        pkt_valid = (cnt_q != '0);
        pop       = data_routed && pkt_valid;
        idx       = (MSB_FIRST != 0) ? WcntW'(PKT_BYTES - 1) - wcnt_q : wcnt_q;
        pkt_next       = asm_q;
        pkt_next[idx]  = data_in;
        pkt_data  = mem_q[rd_ptr_q];
        pkt_count = cnt_q;
        overflow  = ovf_q;
    end

    // Next-state for counter, pointers, occupancy and the sticky overflow flag
    always_comb begin
        wcnt_d   = wcnt_q;
        asm_d    = asm_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (node_transfering && !in_ready);
        if (accept) begin
            asm_d  = pkt_next;
            wcnt_d = last_word ? '0 : wcnt_q + WcntW'(1);
        end
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      cnt_d = cnt_q + CntW'(1);
        else if (!push && pop) cnt_d = cnt_q - CntW'(1);
    end

    // Control and assembly state registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wcnt_q   <= '0;
            asm_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            asm_q    <= asm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Packet storage; the last word bypasses the assembly register into the slot
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= pkt_next;
        end
    end

`ifdef INBUF_PARITY_EN
    logic err_run_q, err_run_d, err_next;
    logic err_mem_q [DEPTH];

    // Running error restarts with the first word of each packet
    always_comb begin
        err_next  = ((wcnt_q == '0) ? 1'b0 : err_run_q) | (^{data_in, data_parity_in});
        err_run_d = accept ? err_next : err_run_q;
        pkt_error = err_mem_q[rd_ptr_q];
    end

    // Running error bit and per-slot error storage
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_run_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) err_mem_q[i] <= 1'b0;
        end else begin
            err_run_q <= err_run_d;
            if (push) err_mem_q[wr_ptr_q] <= err_next;
        end
    end
`endif

endmodule

// File: tb/tb_input_packet_queue.sv
// Directed bench for input_packet_queue: a default (MSB-first) instance and an
// LSB-first instance share one stimulus stream.
module tb_input_packet_queue;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic node_transfering = 1'b0;
    logic [7:0] data_in = '0;
    logic data_parity_in = 1'b0;
    logic data_routed = 1'b0;

    logic            in_ready_a, pkt_valid_a, overflow_a, pkt_error_a;
    logic [3:0][7:0] pkt_data_a;
    logic [1:0]      pkt_count_a;
    logic            in_ready_b, pkt_valid_b, overflow_b, pkt_error_b;
    logic [3:0][7:0] pkt_data_b;
    logic [1:0]      pkt_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    input_packet_queue #(.DATA_W(8), .PKT_BYTES(4), .DEPTH(2), .MSB_FIRST(1)) dut_a (
        .clock            (clock),
        .reset_n          (reset_n),
        .node_transfering (node_transfering),
        .data_in          (data_in),
`ifdef INBUF_PARITY_EN
        .data_parity_in   (data_parity_in),
        .pkt_error        (pkt_error_a),
`endif
        .in_ready         (in_ready_a),
        .data_routed      (data_routed),
        .pkt_valid        (pkt_valid_a),
        .pkt_data         (pkt_data_a),
        .pkt_count        (pkt_count_a),
        .overflow         (overflow_a)
    );

    input_packet_queue #(.DATA_W(8), .PKT_BYTES(4), .DEPTH(2), .MSB_FIRST(0)) dut_b (
        .clock            (clock),
        .reset_n          (reset_n),
        .node_transfering (node_transfering),
        .data_in          (data_in),
`ifdef INBUF_PARITY_EN
        .data_parity_in   (data_parity_in),
        .pkt_error        (pkt_error_b),
`endif
        .in_ready         (in_ready_b),
        .data_routed      (data_routed),
        .pkt_valid        (pkt_valid_b),
        .pkt_data         (pkt_data_b),
        .pkt_count        (pkt_count_b),
        .overflow         (overflow_b)
    );

`ifndef INBUF_PARITY_EN
    assign pkt_error_a = 1'b0;
    assign pkt_error_b = 1'b0;
`endif

    // One cycle of stimulus; outputs are sampled 1 time unit after the edge
    task automatic word(input logic [7:0] d, input bit bad, input bit route);
        node_transfering = 1'b1;
        data_in          = d;
        data_parity_in   = (^d) ^ bad;
        data_routed      = route;
        @(posedge clock); #1;
        node_transfering = 1'b0;
        data_routed      = 1'b0;
    endtask

    task automatic pop_one();
        data_routed = 1'b1;
        @(posedge clock); #1;
        data_routed = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] p);
        for (int i = 3; i >= 0; i--) word(p[i*8 +: 8], 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pkt_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pkt_valid_a); end
        checks++; if (pkt_count_a !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", pkt_count_a); end
        checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow_a); end
        checks++; if (pkt_data_a !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", pkt_data_a); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_a); end
    endtask

    task automatic test_basic();
        do_reset();
        word(8'h11, 1'b0, 1'b0);
        word(8'h22, 1'b0, 1'b0);
        word(8'h33, 1'b0, 1'b0);
        checks++; if (pkt_valid_a !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", pkt_valid_a); end
        word(8'h44, 1'b0, 1'b0);
        checks++; if (pkt_valid_a !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", pkt_valid_a); end
        checks++; if (pkt_data_a !== 32'h11223344) begin errors++; $display("FAIL basic_data got %h want 11223344", pkt_data_a); end
        checks++; if (pkt_count_a !== 2'd1) begin errors++; $display("FAIL basic_count got %0d want 1", pkt_count_a); end
        checks++; if (pkt_data_b !== 32'h44332211) begin errors++; $display("FAIL byte_order got %h want 44332211", pkt_data_b); end
        pop_one();
        checks++; if (pkt_valid_a !== 1'b0 || pkt_count_a !== 2'd0) begin
            errors++; $display("FAIL basic_pop got valid %b count %0d want 0 0", pkt_valid_a, pkt_count_a); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 11; i++) word(8'(i), 1'b0, 1'b0);
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready_a); end
        checks++; if (pkt_count_a !== 2'd2) begin errors++; $display("FAIL full_count got %0d want 2", pkt_count_a); end
        checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL full_early_ovf got %b want 0", overflow_a); end
        word(8'h0C, 1'b0, 1'b0);
        checks++; if (overflow_a !== 1'b1) begin errors++; $display("FAIL full_overflow got %b want 1", overflow_a); end
        checks++; if (pkt_count_a !== 2'd2) begin errors++; $display("FAIL full_drop_count got %0d want 2", pkt_count_a); end
        checks++; if (pkt_data_a !== 32'h01020304) begin errors++; $display("FAIL full_head1 got %h want 01020304", pkt_data_a); end
        pop_one();
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b want 1", in_ready_a); end
        checks++; if (pkt_data_a !== 32'h05060708) begin errors++; $display("FAIL full_head2 got %h want 05060708", pkt_data_a); end
        word(8'h0C, 1'b0, 1'b0);
        checks++; if (pkt_count_a !== 2'd2) begin errors++; $display("FAIL full_resend_count got %0d want 2", pkt_count_a); end
        checks++; if (overflow_a !== 1'b1) begin errors++; $display("FAIL full_sticky got %b want 1", overflow_a); end
        pop_one();
        checks++; if (pkt_data_a !== 32'h090A0B0C) begin errors++; $display("FAIL full_head3 got %h want 090a0b0c", pkt_data_a); end
        checks++; if (pkt_data_b !== 32'h0C0B0A09) begin errors++; $display("FAIL full_head3_lsb got %h want 0c0b0a09", pkt_data_b); end
        pop_one();
        checks++; if (pkt_count_a !== 2'd0) begin errors++; $display("FAIL full_drain got %0d want 0", pkt_count_a); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        send_pkt(32'hA1A2A3A4);
        word(8'hB1, 1'b0, 1'b0);
        word(8'hB2, 1'b0, 1'b0);
        word(8'hB3, 1'b0, 1'b0);
        word(8'hB4, 1'b0, 1'b1);
        checks++; if (pkt_count_a !== 2'd1) begin errors++; $display("FAIL simul_count got %0d want 1", pkt_count_a); end
        checks++; if (pkt_data_a !== 32'hB1B2B3B4) begin errors++; $display("FAIL simul_head got %h want b1b2b3b4", pkt_data_a); end
        pop_one();
        pop_one();
        checks++; if (pkt_count_a !== 2'd0 || pkt_valid_a !== 1'b0) begin
            errors++; $display("FAIL empty_pop got count %0d valid %b want 0 0", pkt_count_a, pkt_valid_a); end
        send_pkt(32'hC1C2C3C4);
        checks++; if (pkt_count_a !== 2'd1) begin errors++; $display("FAIL after_empty_pop got %0d want 1", pkt_count_a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_pkt(32'hD1D2D3D4);
        word(8'hE1, 1'b0, 1'b0);
        word(8'hE2, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(posedge clock); #1;
        checks++; if (pkt_valid_a !== 1'b0 || pkt_count_a !== 2'd0) begin
            errors++; $display("FAIL mid_reset_q got valid %b count %0d want 0 0", pkt_valid_a, pkt_count_a); end
        checks++; if (pkt_data_a !== 32'h0) begin errors++; $display("FAIL mid_reset_data got %h want 0", pkt_data_a); end
        reset_n = 1'b1;
        send_pkt(32'h5A6B7C8D);
        checks++; if (pkt_data_a !== 32'h5A6B7C8D || pkt_count_a !== 2'd1) begin
            errors++; $display("FAIL mid_clean got %h count %0d want 5a6b7c8d 1", pkt_data_a, pkt_count_a); end
        checks++; if (pkt_data_b !== 32'h8D7C6B5A) begin errors++; $display("FAIL mid_clean_lsb got %h want 8d7c6b5a", pkt_data_b); end
    endtask

`ifdef INBUF_PARITY_EN
    task automatic test_parity();
        do_reset();
        word(8'h01, 1'b0, 1'b0);
        word(8'h02, 1'b0, 1'b0);
        word(8'h03, 1'b1, 1'b0);
        word(8'h04, 1'b0, 1'b0);
        send_pkt(32'h05060708);
        checks++; if (pkt_error_a !== 1'b1) begin errors++; $display("FAIL parity_bad got %b want 1", pkt_error_a); end
        pop_one();
        checks++; if (pkt_error_a !== 1'b0) begin errors++; $display("FAIL parity_clean got %b want 0", pkt_error_a); end
        checks++; if (pkt_data_a !== 32'h05060708) begin errors++; $display("FAIL parity_data got %h want 05060708", pkt_data_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_simultaneous();
        test_reset_mid();
`ifdef INBUF_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
